// File: rtl/arb_stream_mux.sv
// N-to-1 frame multiplexer driven by an external blocking arbiter grant.
// Forwards one whole frame from the granted port through an output register plus skid entry, then acknowledges.
`timescale 1ns/1ps
module arb_stream_mux #(
  parameter int PORTS      = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [PORTS*DATA_WIDTH-1:0] s_tdata,
  input  logic [PORTS-1:0]            s_tvalid,
  input  logic [PORTS-1:0]            s_tlast,
  output logic [PORTS-1:0]            s_tready,
  output logic [DATA_WIDTH-1:0]       m_tdata,
  output logic                        m_tvalid,
  output logic                        m_tlast,
  input  logic                        m_tready,
  output logic [PORTS-1:0]            arb_request,
  output logic [PORTS-1:0]            arb_acknowledge,
  input  logic                        arb_grant_valid,
  input  logic [$clog2(PORTS)-1:0]    arb_grant_encoded
);

  localparam int SelWidth = $clog2(PORTS);

  typedef enum logic [1:0] {IDLE, XFER, ACK} state_t;

  state_t                state_q;
  logic [SelWidth-1:0]   sel_q;
  logic [DATA_WIDTH-1:0] outData_q;
  logic                  outValid_q;
  logic                  outLast_q;
  logic [DATA_WIDTH-1:0] skidData_q;
  logic                  skidLast_q;
  logic                  skidValid_q;

  logic [DATA_WIDTH-1:0] selData;
  logic                  selValid;
  logic                  selLast;
  logic                  accept;
  logic                  outFree;

  assign selData  = s_tdata[int'(sel_q)*DATA_WIDTH +: DATA_WIDTH];
  assign selValid = s_tvalid[sel_q];
  assign selLast  = s_tlast[sel_q];
  assign accept   = (state_q == XFER) && selValid && !skidValid_q;
  assign outFree  = !outValid_q || m_tready;

  assign arb_request     = rst ? '0 : s_tvalid;
  assign arb_acknowledge = (state_q == ACK) ? ({{(PORTS-1){1'b0}}, 1'b1} << sel_q) : '0;

  assign m_tdata  = outData_q;
  assign m_tvalid = outValid_q;
  assign m_tlast  = outLast_q;

  // Only the selected port may be ready, and only while the skid entry has room.
  always_comb begin
    s_tready = '0;
    if (state_q == XFER) begin
      s_tready[sel_q] = !skidValid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      outData_q   <= '0;
      outValid_q  <= 1'b0;
      outLast_q   <= 1'b0;
      skidData_q  <= '0;
      skidLast_q  <= 1'b0;
      skidValid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (arb_grant_valid) begin
            sel_q   <= arb_grant_encoded;
            state_q <= XFER;
          end
        end
        XFER: begin
          if (accept && selLast) begin
            state_q <= ACK;
          end
        end
        ACK:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase

      // A full skid always holds the older beat, so it refills the output before any new input.
      if (outFree) begin
        if (skidValid_q) begin
          outData_q   <= skidData_q;
          outLast_q   <= skidLast_q;
          outValid_q  <= 1'b1;
          skidValid_q <= 1'b0;
        end else if (accept) begin
          outData_q  <= selData;
          outLast_q  <= selLast;
          outValid_q <= 1'b1;
        end else begin
          outValid_q <= 1'b0;
        end
      end else if (accept) begin
        skidData_q  <= selData;
        skidLast_q  <= selLast;
        skidValid_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_arb_stream_mux.sv
// Directed bench for arb_stream_mux with a round-robin blocking arbiter and a frame-order scoreboard.
// Sources hold per-port beat queues; the arbiter model decides which frame must appear on the output next.
`timescale 1ns/1ps
module tb_arb_stream_mux;

  localparam int P  = 4;
  localparam int DW = 8;
  localparam int SW = $clog2(P);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [P*DW-1:0] s_tdata  = '0;
  logic [P-1:0]  s_tvalid = '0;
  logic [P-1:0]  s_tlast  = '0;
  logic [P-1:0]  s_tready;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tlast;
  logic          m_tready = 1'b1;
  logic [P-1:0]  arb_request;
  logic [P-1:0]  arb_acknowledge;
  logic          arbGrantValid = 1'b0;
  logic [SW-1:0] arbGrantEncoded = '0;

  int compared = 0;
  int mismatched = 0;
  int cycle = 0;

  // Source queues and expected output stream, each entry {tlast, data}.
  logic [8:0] srcQ [P][$];
  logic [8:0] expQ [$];

  // Arbiter model state.
  logic gValid = 1'b0;
  int   gIdx = 0;
  int   lastIdx = P - 1;

  int acceptCount = 0;
  int outCount = 0;
  logic [P-1:0] expAck = '0;

  int           acceptCyc [$];
  int           outCyc [$];
  logic [7:0]   outData [$];
  logic         outLast [$];
  int           ackCyc [$];
  logic [P-1:0] ackVal [$];

  arb_stream_mux #(.PORTS(P), .DATA_WIDTH(DW)) dut (
    .clk               (clk),
    .rst               (rst),
    .s_tdata           (s_tdata),
    .s_tvalid          (s_tvalid),
    .s_tlast           (s_tlast),
    .s_tready          (s_tready),
    .m_tdata           (m_tdata),
    .m_tvalid          (m_tvalid),
    .m_tlast           (m_tlast),
    .m_tready          (m_tready),
    .arb_request       (arb_request),
    .arb_acknowledge   (arb_acknowledge),
    .arb_grant_valid   (arbGrantValid),
    .arb_grant_encoded (arbGrantEncoded)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  function automatic logic [P-1:0] onehot(int i);
    logic [P-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic applyStimulus(int p, logic [7:0] d, logic l);
    srcQ[p].push_back({l, d});
  endtask

  task automatic clearLogs();
    acceptCyc.delete();
    outCyc.delete();
    outData.delete();
    outLast.delete();
    ackCyc.delete();
    ackVal.delete();
  endtask

  function automatic bit srcEmpty();
    bit e;
    e = 1'b1;
    for (int p = 0; p < P; p++) if (srcQ[p].size() != 0) e = 1'b0;
    return e;
  endfunction

  task automatic waitDrain(string name);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    while (!done && n < 300) begin
      @(posedge clk); #2;
      n++;
      done = (expQ.size() == 0) && !gValid && srcEmpty();
    end
    if (!done) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL %s: drain timeout, got busy, expected idle", name);
    end
    repeat (2) @(posedge clk);
    #2;
  endtask

  task automatic waitAccepts(string name, int count);
    int n;
    n = 0;
    while (acceptCyc.size() < count && n < 100) begin
      @(posedge clk); #2;
      n++;
    end
    if (acceptCyc.size() < count) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL %s: accept timeout, got %0d beats, expected %0d", name, acceptCyc.size(), count);
    end
  endtask

  // Model: sample mid-cycle, compare, then advance sources, arbiter and scoreboard just after the edge.
  initial begin : modelProc
    logic [P-1:0] hsS, ackS, reqS, allowed;
    logic         mHsS, rstS, lastHsS;
    logic [8:0]   beat, head;
    int           idx;
    forever begin
      @(negedge clk);
      reqS    = arb_request;
      ackS    = arb_acknowledge;
      rstS    = rst;
      hsS     = s_tvalid & s_tready;
      mHsS    = m_tvalid & m_tready;
      lastHsS = |(hsS & s_tlast);
      allowed = gValid ? onehot(gIdx) : '0;

      checkOutput("arb_request", 32'(arb_request), rst ? 32'(0) : 32'(s_tvalid));
      checkOutput("arb_acknowledge", 32'(arb_acknowledge), 32'(expAck));
      checkOutput("s_tready_granted_only", 32'(s_tready & ~allowed), 32'(0));
      if (acceptCount - outCount >= 2)
        checkOutput("s_tready_skid_full", 32'(s_tready), 32'(0));

      if (ackS != '0) begin
        ackCyc.push_back(cycle);
        ackVal.push_back(ackS);
      end
      for (int p = 0; p < P; p++) begin
        if (hsS[p]) begin
          acceptCount++;
          acceptCyc.push_back(cycle);
        end
      end
      if (mHsS) begin
        if (expQ.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL unexpected_output: got beat %0h, expected none", m_tdata);
        end else begin
          beat = expQ.pop_front();
          checkOutput("m_tdata", 32'(m_tdata), 32'(beat[7:0]));
          checkOutput("m_tlast", 32'(m_tlast), 32'(beat[8]));
        end
        outCount++;
        outData.push_back(m_tdata);
        outLast.push_back(m_tlast);
        outCyc.push_back(cycle);
      end

      @(posedge clk); #1;
      if (rstS) begin
        expQ.delete();
        gValid = 1'b0;
        gIdx = 0;
        lastIdx = P - 1;
        acceptCount = 0;
        outCount = 0;
        expAck = '0;
      end else begin
        expAck = (gValid && lastHsS && hsS[gIdx]) ? onehot(gIdx) : '0;
        for (int p = 0; p < P; p++)
          if (hsS[p] && srcQ[p].size() > 0) void'(srcQ[p].pop_front());
        if (!gValid || ackS == onehot(gIdx)) begin
          gValid = 1'b0;
          for (int k = 1; k <= P; k++) begin
            idx = (lastIdx + k) % P;
            if (!gValid && reqS[idx]) begin
              gValid = 1'b1;
              gIdx = idx;
            end
          end
          if (gValid) begin
            lastIdx = gIdx;
            for (int j = 0; j < srcQ[gIdx].size(); j++) begin
              expQ.push_back(srcQ[gIdx][j]);
              if (srcQ[gIdx][j][8]) break;
            end
          end
        end
      end

      for (int p = 0; p < P; p++) begin
        if (srcQ[p].size() > 0) begin
          head = srcQ[p][0];
          s_tvalid[p] = 1'b1;
          s_tdata[p*DW +: DW] = head[7:0];
          s_tlast[p] = head[8];
        end else begin
          s_tvalid[p] = 1'b0;
          s_tdata[p*DW +: DW] = '0;
          s_tlast[p] = 1'b0;
        end
      end
      arbGrantValid   = gValid;
      arbGrantEncoded = SW'(gIdx);
    end
  end

  initial begin : watchdog
    #1000000;
    $display("[TB] FAIL watchdog: got no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int loadCyc;

    // Reset values.
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_m_tvalid", 32'(m_tvalid), 32'(0));
    checkOutput("reset_m_tdata", 32'(m_tdata), 32'(0));
    checkOutput("reset_m_tlast", 32'(m_tlast), 32'(0));
    checkOutput("reset_s_tready", 32'(s_tready), 32'(0));
    checkOutput("reset_arb_ack", 32'(arb_acknowledge), 32'(0));
    @(posedge clk); #2;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #2;

    // Single 3-beat frame on port 2.
    $display("[TB] test 1: single port");
    clearLogs();
    applyStimulus(2, 8'hA0, 1'b0);
    applyStimulus(2, 8'hA1, 1'b0);
    applyStimulus(2, 8'hA2, 1'b1);
    loadCyc = cycle;
    @(posedge clk);
    @(negedge clk);
    checkOutput("t1_arb_request", 32'(arb_request), 32'h4);
    waitDrain("t1");
    checkOutput("t1_out_count", 32'(outData.size()), 32'd3);
    checkOutput("t1_data0", 32'(outData[0]), 32'hA0);
    checkOutput("t1_data1", 32'(outData[1]), 32'hA1);
    checkOutput("t1_data2", 32'(outData[2]), 32'hA2);
    checkOutput("t1_tlast", 32'({outLast[2], outLast[1], outLast[0]}), 32'b100);
    checkOutput("t1_first_accept_cycle", 32'(acceptCyc[0]), 32'(loadCyc + 3));
    checkOutput("t1_latency", 32'(outCyc[0] - acceptCyc[0]), 32'd1);
    checkOutput("t1_no_bubbles", 32'(outCyc[2] - outCyc[0]), 32'd2);
    checkOutput("t1_ack_count", 32'(ackVal.size()), 32'd1);
    checkOutput("t1_ack_value", 32'(ackVal[0]), 32'h4);
    checkOutput("t1_ack_cycle", 32'(ackCyc[0] - acceptCyc[2]), 32'd1);

    // Ports 0 and 3 contend; the round-robin pointer last served port 2, so port 3 wins first.
    $display("[TB] test 2: contention");
    clearLogs();
    applyStimulus(0, 8'h01, 1'b0);
    applyStimulus(0, 8'h02, 1'b1);
    applyStimulus(3, 8'h31, 1'b0);
    applyStimulus(3, 8'h32, 1'b1);
    waitDrain("t2");
    checkOutput("t2_out_count", 32'(outData.size()), 32'd4);
    checkOutput("t2_order", {outData[0], outData[1], outData[2], outData[3]}, 32'h31320102);
    checkOutput("t2_ack_count", 32'(ackVal.size()), 32'd2);
    checkOutput("t2_ack0", 32'(ackVal[0]), 32'h8);
    checkOutput("t2_ack1", 32'(ackVal[1]), 32'h1);
    checkOutput("t2_turnaround", 32'(acceptCyc[2] - ackCyc[0]), 32'd2);

    // Backpressure: m_tready low for 3 cycles right after the first beat is accepted.
    $display("[TB] test 3: backpressure");
    clearLogs();
    for (int i = 0; i < 4; i++) applyStimulus(1, 8'(i), i == 3);
    waitAccepts("t3", 1);
    m_tready = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    m_tready = 1'b1;
    waitDrain("t3");
    checkOutput("t3_out_count", 32'(outData.size()), 32'd4);
    checkOutput("t3_order", {outData[0], outData[1], outData[2], outData[3]}, 32'h00010203);
    checkOutput("t3_stall_gap", 32'(acceptCyc[2] - acceptCyc[1]), 32'd4);
    checkOutput("t3_drain_no_bubbles", 32'(outCyc[3] - outCyc[0]), 32'd3);
    checkOutput("t3_ack_value", 32'(ackVal[0]), 32'h2);

    // Back-to-back single-beat frames on port 0.
    $display("[TB] test 4: single-beat frames");
    clearLogs();
    applyStimulus(0, 8'h11, 1'b1);
    applyStimulus(0, 8'h22, 1'b1);
    waitDrain("t4");
    checkOutput("t4_out_count", 32'(outData.size()), 32'd2);
    checkOutput("t4_data", {16'h0, outData[0], outData[1]}, 32'h1122);
    checkOutput("t4_ack_count", 32'(ackVal.size()), 32'd2);
    checkOutput("t4_acks", 32'({ackVal[0], ackVal[1]}), 32'h11);
    checkOutput("t4_accept_gap", 32'(acceptCyc[1] - acceptCyc[0]), 32'd3);

    // Mid-frame reset with two beats held in the output and skid registers.
    $display("[TB] test 5: mid-frame reset");
    clearLogs();
    m_tready = 1'b0;
    applyStimulus(2, 8'h50, 1'b0);
    applyStimulus(2, 8'h51, 1'b0);
    applyStimulus(2, 8'h52, 1'b0);
    applyStimulus(2, 8'h53, 1'b1);
    waitAccepts("t5", 2);
    srcQ[2].delete();
    applyStimulus(3, 8'h3A, 1'b0);
    applyStimulus(3, 8'h3B, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("t5_request_in_reset", 32'(arb_request), 32'(0));
    @(posedge clk); #2;
    rst = 1'b0;
    m_tready = 1'b1;
    @(negedge clk);
    checkOutput("t5_m_tvalid", 32'(m_tvalid), 32'(0));
    checkOutput("t5_m_tdata", 32'(m_tdata), 32'(0));
    checkOutput("t5_m_tlast", 32'(m_tlast), 32'(0));
    checkOutput("t5_s_tready", 32'(s_tready), 32'(0));
    checkOutput("t5_arb_ack", 32'(arb_acknowledge), 32'(0));
    waitDrain("t5");
    checkOutput("t5_out_count", 32'(outData.size()), 32'd2);
    checkOutput("t5_data", {16'h0, outData[0], outData[1]}, 32'h3A3B);
    checkOutput("t5_ack_count", 32'(ackVal.size()), 32'd1);
    checkOutput("t5_ack_value", 32'(ackVal[0]), 32'h8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/arb_stream_mux.md
# arb_stream_mux

Grant-side consumer for the `arbiter` block: an N-input, 1-output packet stream multiplexer. It drives `request` and `acknowledge` to an external `arbiter` instantiated with ARB_BLOCK=1 and ARB_BLOCK_ACK=1. It consumes `grant_valid` and `grant_encoded` to select one input, forwards one whole frame (through tlast) to a registered output with a skid buffer, and then acknowledges. It sits between per-source stream ports and a shared downstream sink.

## Interface
- PORTS, 4: number of input streams; must be ≥2.
- DATA_WIDTH, 8: beat width in bits.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- s_tdata  in  PORTS*DATA_WIDTH  input data; port i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- s_tvalid  in  PORTS  per-port beat valid
- s_tlast  in  PORTS  per-port end of frame
- s_tready  out  PORTS  per-port ready
- m_tdata  out  DATA_WIDTH  output data
- m_tvalid  out  1  output valid
- m_tlast  out  1  output end of frame
- m_tready  in  1  output ready
- arb_request  out  PORTS  to arbiter `request`
- arb_acknowledge  out  PORTS  to arbiter `acknowledge`
- arb_grant_valid  in  1  from arbiter `grant_valid`
- arb_grant_encoded  in  $clog2(PORTS)  from arbiter `grant_encoded`

## Operation
- arb_request = s_tvalid, forced to 0 while rst is high. The signal is combinational.
- The state machine has three states: IDLE, XFER and ACK.
  - IDLE: s_tready = 0. If arb_grant_valid=1, sel_reg <= arb_grant_encoded and the next state is XFER.
  - XFER: s_tready[sel_reg] = !skid_valid; all other s_tready bits are 0. A beat is accepted when s_tvalid[sel_reg] and s_tready[sel_reg] are both high. Acceptance of a beat with s_tlast[sel_reg]=1 moves the state to ACK.
  - ACK: s_tready = 0. arb_acknowledge = one-hot(sel_reg) for exactly this cycle. The next state is IDLE.
- arb_acknowledge is 0 in every state except ACK.
- The output stage is an output register plus a one-entry skid register.
  - Accepted beat, output register empty or draining (m_tready=1): the beat loads the output register.
  - Accepted beat otherwise: the beat goes to skid; skid_valid <= 1.
  - When the output drains and skid_valid=1: the skid contents move to the output register and skid_valid <= 0.
- Beats from different frames never interleave. Beat order is preserved.
- In IDLE, sel_reg is loaded only when arb_grant_valid=1. Any other arb_grant_encoded value is ignored.
- Output backpressure does not stall the state machine in ACK or IDLE. Buffered beats keep draining while those states run.

## Timing
- Reset values: state=IDLE, sel_reg=0, m_tvalid=0, m_tdata=0, m_tlast=0, skid_valid=0, s_tready=0, arb_acknowledge=0, arb_request=0.
- rst asserted mid-frame:
  - The frame is abandoned and buffered beats are discarded.
  - No acknowledge is issued. The arbiter is reset on the same rst.
- Grant to first input beat: arb_grant_valid seen in IDLE at cycle G; s_tready high from G+1.
- Input to output: a beat accepted at cycle T appears with m_tvalid=1 at T+1 if the output register is free.
- Frame turnaround:
  - The last beat is accepted at cycle L; ACK is at L+1.
  - The arbiter updates its grant at the end of L+1.
  - IDLE at L+2 samples the new grant; XFER starts at L+3.
  - The minimum gap between frames at the input is therefore 2 cycles.
- Throughput:
  - Within a frame, one beat per cycle is sustained while m_tready=1.
  - Under backpressure, at most 2 beats are buffered and s_tready drops the cycle after skid fills.
- Single-beat frame: one accept in XFER, then ACK.
- Zero bubbles on the output when m_tready holds high within a frame.
- A grant that is stale during ACK is never sampled.

## Test plan
- Single port:
  - Stimulus: port 2 sends a 3-beat frame (0xA0, 0xA1, 0xA2 with tlast), m_tready=1.
  - Required: arb_request=4'b0100; m_tdata = A0, A1, A2 on consecutive cycles; m_tlast on A2 only; arb_acknowledge=4'b0100 for one cycle, the cycle after A2 is accepted.
- Contention:
  - Stimulus: ports 0 and 3 each hold a 2-beat frame; round-robin arbiter.
  - Required: the two frames are output whole and non-interleaved, in grant order; exactly one acknowledge pulse per frame, on the matching bit.
- Backpressure:
  - Stimulus: 4-beat frame on port 1, m_tready low for 3 cycles mid-frame.
  - Required: no beat is lost or duplicated; s_tready[1]=0 while skid is full; data order 0..3 is preserved.
- Single-beat frames:
  - Stimulus: port 0 sends back-to-back 1-beat frames 0x11 and 0x22.
  - Required: two acknowledge pulses; an input gap of ≥2 cycles between accepts.
- Mid-frame reset:
  - Stimulus: rst asserted after 2 of 4 beats, then a new frame on port 3.
  - Required: all outputs are at reset values the cycle after rst; no acknowledge for the aborted frame; the new frame passes intact.
